// File: rtl/cpu_loader_pkg.sv
// ============================================================================
// Module  : cpu_loader_pkg
// Brief   : Shared types and constants for the instruction memory loader.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_loader_pkg;

  localparam int WORD_BYTES = 4;
  localparam int BYTE_W     = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR   = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_CSUM  = 3'd4,
    S_DONE  = 3'd5,
    S_ERROR = 3'd6
  } state_e;

endpackage

`default_nettype wire

// File: rtl/byte_word_packer.sv
// ============================================================================
// Module  : byte_word_packer
// Brief   : Shifts bytes into a big-endian word; flags the completing byte.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module byte_word_packer
  import cpu_loader_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clr,
  input  logic                         byte_en,
  input  logic [BYTE_W-1:0]            byte_in,
  output logic                         word_valid,
  output logic [WORD_BYTES*BYTE_W-1:0] word
);

  localparam int CNT_W = $clog2(WORD_BYTES);
  localparam int SR_W  = (WORD_BYTES - 1) * BYTE_W;

  logic [SR_W-1:0]  sr_q,  sr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The completing byte is taken straight from the input so the word is
  // available in the same cycle it is accepted.
  assign word_valid = byte_en && (cnt_q == CNT_W'(WORD_BYTES - 1));
  assign word       = {sr_q, byte_in};

  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (clr) begin
      sr_d  = '0;
      cnt_d = '0;
    end else if (byte_en) begin
      sr_d  = {sr_q[SR_W-BYTE_W-1:0], byte_in};
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/instr_mem_loader.sv
// ============================================================================
// Module  : instr_mem_loader
// Brief   : Loads a length-prefixed byte stream into instruction memory while
//           holding the CPU. Optional trailing XOR checksum: LOADER_CHECKSUM_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_mem_loader
  import cpu_loader_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        start,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        InsMemRW,
  output logic [31:0] IAddr,
  output logic [31:0] IDataIn,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  localparam logic [15:0] C_MEM_WORDS = 16'(MEM_WORDS);

  state_e      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [15:0] idx_q, idx_d;
  logic        byte_ready_q, byte_ready_d;
  logic        ins_mem_rw_q, ins_mem_rw_d;
  logic [31:0] iaddr_q, iaddr_d;
  logic [31:0] idata_q, idata_d;
  logic        cpu_hold_q, cpu_hold_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  csum_q, csum_d;
`endif

  logic        w_accept;
  logic        w_word_valid;
  logic [31:0] w_word;

  assign w_accept = byte_valid && byte_ready_q;

  byte_word_packer u_packer (
    .clk        (CLK),
    .rst_n      (Reset),
    .clr        (w_accept && (state_q == S_HDR)),
    .byte_en    (w_accept && (state_q == S_DATA)),
    .byte_in    (byte_in),
    .word_valid (w_word_valid),
    .word       (w_word)
  );

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    idx_d        = idx_q;
    iaddr_d      = iaddr_q;
    idata_d      = idata_q;
    ins_mem_rw_d = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    csum_d       = csum_q;
`endif

    case (state_q)
      S_IDLE: if (start) state_d = S_HDR;
      S_HDR: begin
        if (w_accept) begin
          if (byte_in == 8'd0) begin
            state_d = S_DONE;
          end else if ({8'd0, byte_in} > C_MEM_WORDS) begin
            state_d = S_ERROR;
          end else begin
            len_d   = {8'd0, byte_in};
            idx_d   = '0;
            state_d = S_DATA;
`ifdef LOADER_CHECKSUM_EN
            csum_d  = '0;
`endif
          end
        end
      end
      S_DATA: begin
`ifdef LOADER_CHECKSUM_EN
        if (w_accept) csum_d = csum_q ^ byte_in;
`endif
        // Outputs are registered, so the strobe lands in the WRITE cycle.
        if (w_word_valid) begin
          state_d      = S_WRITE;
          ins_mem_rw_d = 1'b1;
          iaddr_d      = BASE_ADDR + {14'd0, idx_q, 2'b00};
          idata_d      = w_word;
        end
      end
      S_WRITE: begin
        idx_d = idx_q + 16'd1;
        if (idx_q + 16'd1 == len_q) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = S_CSUM;
`else
          state_d = S_DONE;
`endif
        end else begin
          state_d = S_DATA;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CSUM: if (w_accept) state_d = (byte_in == csum_q) ? S_DONE : S_ERROR;
`endif
      S_DONE:  if (start) state_d = S_HDR;
      S_ERROR: if (start) state_d = S_HDR;
      default: state_d = S_IDLE;
    endcase

    byte_ready_d = (state_d == S_HDR) || (state_d == S_DATA) || (state_d == S_CSUM);
    cpu_hold_d   = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d       = (state_d == S_DONE);
    error_d      = (state_d == S_ERROR);
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q      <= S_IDLE;
      len_q        <= '0;
      idx_q        <= '0;
      byte_ready_q <= 1'b0;
      ins_mem_rw_q <= 1'b0;
      iaddr_q      <= '0;
      idata_q      <= '0;
      cpu_hold_q   <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      byte_ready_q <= byte_ready_d;
      ins_mem_rw_q <= ins_mem_rw_d;
      iaddr_q      <= iaddr_d;
      idata_q      <= idata_d;
      cpu_hold_q   <= cpu_hold_d;
      done_q       <= done_d;
      error_q      <= error_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  assign byte_ready = byte_ready_q;
  assign InsMemRW   = ins_mem_rw_q;
  assign IAddr      = iaddr_q;
  assign IDataIn    = idata_q;
  assign cpu_hold   = cpu_hold_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_mem_loader.sv
// ============================================================================
// Module  : tb_instr_mem_loader
// Brief   : Randomized scoreboard bench for instr_mem_loader.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_mem_loader;

  localparam int          MEM_WORDS = 64;
  localparam logic [31:0] BASE_ADDR = 32'h0000_0000;

  logic        CLK = 1'b0;
  logic        Reset = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  byte_in = 8'd0;
  logic        byte_valid = 1'b0;
  logic        byte_ready, InsMemRW, cpu_hold, done, error;
  logic [31:0] IAddr, IDataIn;

  int total = 0;
  int bad   = 0;

  logic [63:0] exp_q[$];
  logic [31:0] words[$];
  logic        prev_rw = 1'b0;

  instr_mem_loader #(.MEM_WORDS(MEM_WORDS), .BASE_ADDR(BASE_ADDR)) dut (
    .CLK(CLK), .Reset(Reset), .start(start), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .InsMemRW(InsMemRW),
    .IAddr(IAddr), .IDataIn(IDataIn), .cpu_hold(cpu_hold), .done(done),
    .error(error)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every write strobe must match the oldest expected write.
  always @(negedge CLK) begin
    if (Reset && InsMemRW) begin
      logic [63:0] e;
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_write: addr %h data %h", IAddr, IDataIn);
      end else begin
        e = exp_q.pop_front();
        chk("write_addr", IAddr, e[63:32]);
        chk("write_data", IDataIn, e[31:0]);
      end
      chk("ready_in_write", {31'd0, byte_ready}, 32'd0);
      chk("strobe_one_cycle", {31'd0, prev_rw}, 32'd0);
    end
    prev_rw <= Reset && InsMemRW;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int budget = 0;
    if (gaps) begin
      while ($urandom_range(0, 2) == 0) begin
        byte_valid = 1'b0;
        @(negedge CLK);
      end
    end
    byte_valid = 1'b1;
    byte_in    = b;
    while (!byte_ready && budget < 50) begin
      @(negedge CLK);
      budget++;
    end
    if (!byte_ready) begin
      total++; bad++;
      $display("FAIL byte_ready_timeout: byte %h not accepted", b);
    end
    @(negedge CLK);
    byte_valid = 1'b0;
  endtask

  task automatic wait_status(input bit exp_done, input bit exp_err);
    int t = 0;
    while (!(done || error) && t < 40) begin
      @(negedge CLK);
      t++;
    end
    chk("done", {31'd0, done}, {31'd0, exp_done});
    chk("error", {31'd0, error}, {31'd0, exp_err});
    chk("cpu_hold_end", {31'd0, cpu_hold}, {31'd0, exp_err});
    chk("ready_end", {31'd0, byte_ready}, 32'd0);
    chk("writes_left", exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  // Reference: a header of n words is legal when 1..MEM_WORDS; word k goes to
  // BASE+4k, bytes big-endian; optional trailing byte is XOR of all data bytes.
  task automatic do_load(input int n, input bit gaps, input bit bad_csum, input int start_at);
    logic [7:0]  x;
    logic [7:0]  b;
    logic [31:0] w;
    bit          legal;
    bit          exp_done;
    int          cnt;
    x = 8'd0;
    cnt = 0;
    legal = (n >= 1) && (n <= MEM_WORDS);
    pulse_start();
    chk("hdr_ready", {31'd0, byte_ready}, 32'd1);
    chk("hdr_done_clr", {30'd0, done, error}, 32'd0);
    chk("hdr_hold", {31'd0, cpu_hold}, 32'd1);
    send_byte(8'(n), gaps);
    if (legal) begin
      for (int k = 0; k < n; k++) begin
        w = (k < words.size()) ? words[k] : $urandom;
        for (int j = 0; j < 4; j++) begin
          b = w[31 - 8*j -: 8];
          x ^= b;
          if (cnt == start_at) pulse_start();
          if (j == 3) exp_q.push_back({BASE_ADDR + 32'(4*k), w});
          send_byte(b, gaps);
          cnt++;
        end
      end
    end
    exp_done = (n == 0) || legal;
`ifdef LOADER_CHECKSUM_EN
    if (legal) begin
      send_byte(bad_csum ? (x ^ 8'h01) : x, gaps);
      exp_done = !bad_csum;
    end
`else
    if (bad_csum) x = 8'd0;
`endif
    wait_status(exp_done, !exp_done);
  endtask

  initial begin
    #1;
    chk("rst_outputs", {25'd0, byte_ready, InsMemRW, cpu_hold, done, error, 2'b00}, 32'd0);
    chk("rst_iaddr", IAddr, 32'd0);
    chk("rst_idata", IDataIn, 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    Reset = 1'b1;
    @(negedge CLK);
    chk("idle_ready", {31'd0, byte_ready}, 32'd0);

    // Single known word, stream held valid.
    words = '{32'h2008_0005};
    do_load(1, 1'b0, 1'b0, -1);

    // Three words with random gaps, then a start pulse mid-data.
    words.delete();
    do_load(3, 1'b1, 1'b0, -1);
    do_load(2, 1'b1, 1'b0, 5);

    // Boundaries.
    do_load(0, 1'b0, 1'b0, -1);
    do_load(65, 1'b0, 1'b0, -1);
    do_load(255, 1'b1, 1'b0, -1);
    do_load(MEM_WORDS, 1'b0, 1'b0, -1);

    // Random lengths.
    for (int r = 0; r < 6; r++) do_load(int'($urandom_range(1, 6)), 1'b1, 1'b0, -1);

    // Reset in the middle of the first word of a two-word load.
    pulse_start();
    send_byte(8'd2, 1'b0);
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    Reset = 1'b0;
    #1;
    chk("midrst_outputs", {27'd0, byte_ready, InsMemRW, cpu_hold, done, error}, 32'd0);
    chk("midrst_iaddr", IAddr, 32'd0);
    chk("midrst_idata", IDataIn, 32'd0);
    @(negedge CLK);
    Reset = 1'b1;
    @(negedge CLK);
    do_load(2, 1'b1, 1'b0, -1);

`ifdef LOADER_CHECKSUM_EN
    words = '{32'hAA55_0FF0};
    do_load(1, 1'b0, 1'b0, -1);
    do_load(1, 1'b0, 1'b1, -1);
    words.delete();
    do_load(4, 1'b1, 1'b1, -1);
`endif

    repeat (3) @(negedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
